// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p
// Two-port round-robin arbiter and sequencer placed in front of a single-port
// synchronous memory (16 x 8 by default). Each request that wins arbitration
// turns into exactly one wr or rd strobe cycle on the memory bus. Read data is
// returned to the requester that issued the read, along with a one-cycle
// rvalid pulse.
//
// Ports
//   clk_i            single clock, all logic on posedge
//   rst_ni           asynchronous active-low reset
//   req0_i/req1_i    request; requester holds it with stable fields until gnt
//   we0_i/we1_i      1 = write, 0 = read
//   addr0_i/addr1_i  target address (passed through unmodified)
//   wdata0_i/wdata1_i write data
//   gnt0_o/gnt1_o    one-cycle pulse; the command is on the memory bus this cycle
//   rdata0_o/rdata1_o read data; holds until the next read for that port
//   rvalid0_o/rvalid1_o one-cycle pulse, rdataN valid
//   mem_data_in_o, mem_address_o, mem_wr_o, mem_rd_o  memory command bus
//   mem_data_out_i   memory read data
//   busy_o           high whenever the sequencer is not idle
//
// Timing, with a request sampled at edge k:
//   gnt and strobe are high in the cycle after edge k+1.
//   Read data is captured at edge k+2+RD_LAT, and rvalid is high in the cycle after that edge.
//   A write occupies the sequencer for 2 cycles and a read for 2+RD_LAT cycles.
module mem_arbiter_2p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] mem_data_in_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_wr_o,
  output logic              mem_rd_o,
  input  logic [DATA_W-1:0] mem_data_out_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  // The WAIT counter starts at zero on the first WAIT edge. Its final edge is the
  // one where the count equals RD_LAT, which puts the capture at edge k+2+RD_LAT.
  localparam logic [2:0] LatLast = 3'(RD_LAT);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          lat_q, lat_d;

  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                mem_wr_q, mem_wr_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;

  logic                any_req;
  logic                pick;
  logic                take;

  // Round-robin choice: a lone requester always wins. On a tie, the requester that
  // was not served last wins.
  always_comb begin
    any_req = req0_i | req1_i;
    if (req0_i && req1_i) begin
      pick = ~last_q;
    end else begin
      pick = req1_i;
    end
  end

  // Next-state and next-output logic. The bus outputs are registered, so they
  // appear in the cycle after the ISSUE state decides them. The memory therefore
  // sees its strobe on the edge that follows.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    mem_wr_d   = 1'b0;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    take       = 1'b0;

    case (state_q)
      S_IDLE: begin
        take = any_req;
      end

      S_ISSUE: begin
        gnt0_d     = ~win_q;
        gnt1_d     = win_q;
        mem_wr_d   = we_q;
        mem_rd_d   = ~we_q;
        mem_addr_d = addr_q;
        mem_din_d  = wdata_q;
        lat_d      = 3'd0;
        state_d    = we_q ? S_IDLE : S_WAIT;
      end

      S_WAIT: begin
        if (lat_q == LatLast) begin
          if (win_q) begin
            rdata1_d  = mem_data_out_i;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_data_out_i;
            rvalid0_d = 1'b1;
          end
          lat_d   = 3'd0;
          state_d = S_IDLE;
          // The edge that finishes a read can also accept the next request, so
          // back-to-back reads have no idle gap.
          take    = any_req;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accepting a request latches the winner's whole command. The loser's request
    // simply stays pending until a later sampling edge.
    if (take) begin
      win_d   = pick;
      last_d  = pick;
      we_d    = pick ? we1_i    : we0_i;
      addr_d  = pick ? addr1_i  : addr0_i;
      wdata_d = pick ? wdata1_i : wdata0_i;
      state_d = S_ISSUE;
    end
  end

  // State and output registers. The pointer resets to port 1, so that port 0 wins
  // the first tie. Reset drops any read in flight without producing an rvalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_q      <= 3'd0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign gnt0_o        = gnt0_q;
  assign gnt1_o        = gnt1_q;
  assign rdata0_o      = rdata0_q;
  assign rdata1_o      = rdata1_q;
  assign rvalid0_o     = rvalid0_q;
  assign rvalid1_o     = rvalid1_q;
  assign mem_data_in_o = mem_din_q;
  assign mem_address_o = mem_addr_q;
  assign mem_wr_o      = mem_wr_q;
  assign mem_rd_o      = mem_rd_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb_mem_arbiter_2p
// Bench for mem_arbiter_2p.
// The main instance uses RD_LAT=1 and is paired with a behavioural 16x8 memory.
// A second instance uses RD_LAT=3 and exercises the longer read path.
// A timeline model predicts every output cycle by cycle for the main instance.
// Directed scenarios pin specific literal values.
module tb_mem_arbiter_2p;

  localparam int MAXC = 4096;
  localparam int LAT  = 1;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rv0, rv1, memWr, memRd, busy;
  logic [7:0] rd0, rd1, memDin, memDout;
  logic [3:0] memAddr;

  mem_arbiter_2p #(.DATA_W(8), .ADDR_W(4), .RD_LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rdata0_o(rd0), .rdata1_o(rd1),
    .rvalid0_o(rv0), .rvalid1_o(rv1),
    .mem_data_in_o(memDin), .mem_address_o(memAddr), .mem_wr_o(memWr), .mem_rd_o(memRd),
    .mem_data_out_i(memDout), .busy_o(busy)
  );

  // Behavioural single-port memory with one cycle of read latency.
  logic [7:0] envMem [16];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) envMem[i] <= 8'hA0 + 8'(i);
    end else begin
      if (memWr) envMem[memAddr] <= memDin;
      if (memRd) memDout <= envMem[memAddr];
    end
  end

  // Second instance with RD_LAT=3 and its own three-stage memory.
  logic       r3Req, g3a, g3b, rv3a, rv3b, w3, r3, busy3;
  logic [7:0] rd3a, rd3b, din3, dout3;
  logic [3:0] a3;
  logic [7:0] m3 [16];
  logic [7:0] d3 [3];

  mem_arbiter_2p #(.DATA_W(8), .ADDR_W(4), .RD_LAT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(r3Req), .req1_i(1'b0), .we0_i(1'b0), .we1_i(1'b0),
    .addr0_i(4'd5), .addr1_i(4'd0), .wdata0_i(8'd0), .wdata1_i(8'd0),
    .gnt0_o(g3a), .gnt1_o(g3b), .rdata0_o(rd3a), .rdata1_o(rd3b),
    .rvalid0_o(rv3a), .rvalid1_o(rv3b),
    .mem_data_in_o(din3), .mem_address_o(a3), .mem_wr_o(w3), .mem_rd_o(r3),
    .mem_data_out_i(dout3), .busy_o(busy3)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m3[i] <= 8'hA0 + 8'(i);
    end else begin
      if (w3) m3[a3] <= din3;
      if (r3) d3[0] <= m3[a3];
      d3[1] <= d3[0];
      d3[2] <= d3[1];
    end
  end
  assign dout3 = d3[2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit track = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Requester drivers. Each port presents the head of its queue and keeps it
  // stable until it sees its gnt. It then presents the next entry straight away.
  txn_t q0[$];
  txn_t q1[$];
  bit   act0 = 1'b0, act1 = 1'b0;
  int   p0Cyc = 0, p1Cyc = 0;

  initial begin
    txn_t t;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act0 = 0; act1 = 0; req0 = 0; req1 = 0;
      end else begin
        if (act0 && gnt0) begin act0 = 0; req0 = 0; end
        if (act1 && gnt1) begin act1 = 0; req1 = 0; end
        if (!act0 && q0.size() > 0) begin
          t = q0.pop_front();
          we0 = t.we; addr0 = t.addr; wdata0 = t.wdata; req0 = 1; act0 = 1; p0Cyc = cyc;
        end
        if (!act1 && q1.size() > 0) begin
          t = q1.pop_front();
          we1 = t.we; addr1 = t.addr; wdata1 = t.wdata; req1 = 1; act1 = 1; p1Cyc = cyc;
        end
      end
    end
  end

  // Timeline model. Expected outputs are kept per absolute cycle; cycle n means the
  // interval right after posedge n. A request accepted at edge n owns gnt/strobe
  // in cycle n+1. A read owns rvalid in cycle n+2+LAT. The sequencer is free to
  // accept again at edge n+2 (write) or n+2+LAT (read).
  bit         eG0 [MAXC], eG1 [MAXC], eWr [MAXC], eRd [MAXC];
  bit         eV0 [MAXC], eV1 [MAXC], eBusy [MAXC], eIss [MAXC];
  logic [7:0] eD0 [MAXC], eD1 [MAXC], eDin [MAXC];
  logic [3:0] eAddr [MAXC];
  logic [7:0] mdl [16];
  int         nextSample = 0;
  bit         lastSrv = 1'b1;

  initial begin
    int w;
    logic we;
    logic [3:0] a;
    logic [7:0] d;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (!rst_n) begin
        for (int c = 0; c < MAXC; c++) begin
          eG0[c] = 0; eG1[c] = 0; eWr[c] = 0; eRd[c] = 0;
          eV0[c] = 0; eV1[c] = 0; eBusy[c] = 0; eIss[c] = 0;
        end
        for (int i = 0; i < 16; i++) mdl[i] = 8'(160 + i);
        nextSample = 0;
        lastSrv = 1'b1;
      end else if (cyc >= nextSample && (req0 || req1) && cyc + LAT + 3 < MAXC) begin
        if (req0 && req1) w = lastSrv ? 0 : 1;
        else w = req1 ? 1 : 0;
        lastSrv = (w == 1);
        we = (w == 1) ? we1 : we0;
        a  = (w == 1) ? addr1 : addr0;
        d  = (w == 1) ? wdata1 : wdata0;
        if (w == 1) eG1[cyc+1] = 1; else eG0[cyc+1] = 1;
        eIss[cyc+1] = 1; eAddr[cyc+1] = a; eDin[cyc+1] = d;
        if (we) begin
          eWr[cyc+1] = 1;
          mdl[a] = d;
          eBusy[cyc] = 1;
          nextSample = cyc + 2;
        end else begin
          eRd[cyc+1] = 1;
          for (int c = cyc; c <= cyc + 1 + LAT; c++) eBusy[c] = 1;
          if (w == 1) begin eV1[cyc+2+LAT] = 1; eD1[cyc+2+LAT] = mdl[a]; end
          else        begin eV0[cyc+2+LAT] = 1; eD0[cyc+2+LAT] = mdl[a]; end
          nextSample = cyc + 2 + LAT;
        end
      end
    end
  end

  // Compare process. It also logs grant and read-return events, which the directed
  // scenarios use for their literal checks.
  logic [7:0] hR0, hR1, hDin;
  logic [3:0] hAddr;
  int         gq[$];
  logic [7:0] rq0[$];
  int         g0Cyc = 0, g1Cyc = 0, v0Cyc = 0, v1Cyc = 0;
  logic [12:0] g0Cmd;
  logic [7:0] v0Data, v1Data;

  initial begin
    logic [34:0] gotV, expV;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hR0 = 0; hR1 = 0; hDin = 0; hAddr = 0;
      end else begin
        if (cyc < MAXC) begin
          if (eIss[cyc]) begin hAddr = eAddr[cyc]; hDin = eDin[cyc]; end
          if (eV0[cyc]) hR0 = eD0[cyc];
          if (eV1[cyc]) hR1 = eD1[cyc];
        end
        if (gnt0) begin gq.push_back(0); g0Cyc = cyc; g0Cmd = {memWr, memAddr, memDin}; end
        if (gnt1) begin gq.push_back(1); g1Cyc = cyc; end
        if (rv0) begin v0Cyc = cyc; v0Data = rd0; rq0.push_back(rd0); end
        if (rv1) begin v1Cyc = cyc; v1Data = rd1; end
        if (track && cyc < MAXC) begin
          gotV = {gnt0, gnt1, memWr, memRd, rv0, rv1, busy, rd0, rd1, memAddr, memDin};
          expV = {eG0[cyc], eG1[cyc], eWr[cyc], eRd[cyc], eV0[cyc], eV1[cyc], eBusy[cyc],
                  hR0, hR1, hAddr, hDin};
          checkOutput($sformatf("cycle_%0d", cyc), 64'(gotV), 64'(expV));
        end
      end
    end
  end

  function automatic txn_t mk(input logic we, input logic [3:0] a, input logic [7:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // Waits, with a bound, until both queues have drained and the DUT has been idle
  // long enough for any trailing rvalid.
  task automatic applyStimulus(input string name);
    int idle = 0;
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && !act0 && !act1 && !busy) idle++;
      else idle = 0;
      if (idle >= 4) done = 1;
    end
    checkOutput({name, "_complete"}, 64'(done), 64'd1);
  endtask

  task automatic doReset();
    track = 0;
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    track = 1;
  endtask

  initial begin
    int bc, rvAt;
    bit seen, ok;
    logic [7:0] rvD;
    rst_n = 0; r3Req = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                64'({gnt0, gnt1, rv0, rv1, busy, memWr, memRd, rd0, rd1, memAddr, memDin}), 64'd0);
    rst_n = 1;
    @(negedge clk);
    track = 1;

    // Tie with both requesters continuously busy: port 0 wins first, then they alternate.
    $display("[TB] tie test");
    gq.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b1, 4'(8 + i), 8'(16 + i)));
      q1.push_back(mk(1'b1, 4'(12 + i), 8'(32 + i)));
    end
    applyStimulus("tie");
    checkOutput("tie_grant_count", 64'(gq.size()), 64'd8);
    for (int i = 0; i < 8 && i < gq.size(); i++)
      checkOutput($sformatf("tie_grant_%0d", i), 64'(gq[i]), 64'(i % 2));

    // Single write, then a read-back of the same address.
    $display("[TB] single test");
    q0.push_back(mk(1'b1, 4'd3, 8'd15));
    applyStimulus("single_wr");
    checkOutput("single_wr_gnt_latency", 64'(g0Cyc - p0Cyc), 64'd2);
    checkOutput("single_wr_bus", 64'(g0Cmd), 64'({1'b1, 4'd3, 8'd15}));
    q0.push_back(mk(1'b0, 4'd3, 8'd0));
    applyStimulus("single_rd");
    checkOutput("single_rd_latency", 64'(v0Cyc - p0Cyc), 64'd4);
    checkOutput("single_rd_data", 64'(v0Data), 64'd15);

    // Sweep: port 1 writes i*5 to address i, then port 0 reads everything back.
    $display("[TB] sweep test");
    for (int i = 0; i < 16; i++) q1.push_back(mk(1'b1, 4'(i), 8'(i * 5)));
    applyStimulus("sweep_wr");
    rq0.delete();
    for (int i = 0; i < 16; i++) q0.push_back(mk(1'b0, 4'(i), 8'hFF));
    applyStimulus("sweep_rd");
    checkOutput("sweep_count", 64'(rq0.size()), 64'd16);
    for (int i = 0; i < 16 && i < rq0.size(); i++)
      checkOutput($sformatf("sweep_rdata_%0d", i), 64'(rq0[i]), 64'(i * 5));

    // Contention: a port 1 write first makes port 1 the last served. Then the
    // port 0 write and the port 1 read of address 7 arrive on the same edge.
    $display("[TB] contention test");
    q1.push_back(mk(1'b1, 4'd8, 8'h11));
    applyStimulus("contention_pre");
    q0.push_back(mk(1'b1, 4'd7, 8'd42));
    q1.push_back(mk(1'b0, 4'd7, 8'd0));
    applyStimulus("contention");
    checkOutput("contention_gnt_gap", 64'(g1Cyc - g0Cyc), 64'd2);
    checkOutput("contention_rdata1", 64'(v1Data), 64'd42);

    // Reset while a read sits in WAIT.
    $display("[TB] reset-in-wait test");
    track = 0;
    q0.push_back(mk(1'b0, 4'd2, 8'd0));
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (gnt0) ok = 1;
    end
    checkOutput("reset_wait_reached", 64'({ok, busy}), 64'b11);
    #2 rst_n = 0;
    #1 checkOutput("reset_in_wait_outputs",
                   64'({gnt0, gnt1, rv0, rv1, busy, memWr, memRd, rd0, rd1, memAddr, memDin}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | rv0 | rv1 | busy;
    end
    checkOutput("no_rvalid_after_reset", 64'(seen), 64'd0);

    // RD_LAT=3 instance: a single read of address 5.
    $display("[TB] rd_lat3 test");
    @(negedge clk); r3Req = 1;
    bc = 0; rvAt = -1; rvD = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (g3a) r3Req = 0;
      if (busy3) bc++;
      if (rv3a && rvAt < 0) begin rvAt = j; rvD = rd3a; end
    end
    checkOutput("lat3_busy_cycles", 64'(bc), 64'd5);
    checkOutput("lat3_rvalid_edge", 64'(rvAt), 64'd5);
    checkOutput("lat3_rdata", 64'(rvD), 64'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
